// File: rtl/zigzag_pkg.sv
// Shared constants, index type and zigzag <-> raster lookup tables for the
// zigzag reorder buffer (zigzag_reorder_buf, zigzag_bank).
package zigzag_pkg;

   localparam int BLK_N = 64;
   localparam int IDX_W = 6;

   typedef logic [5:0] zz_idx_t;

   // Zigzag scan position -> raster (row*8+col) position within the 8x8 block.
   function automatic zz_idx_t ZZ2RAS(input zz_idx_t idx);
      zz_idx_t r;
      case (idx)
         6'd0:  r = 6'd0;  6'd1:  r = 6'd1;  6'd2:  r = 6'd8;  6'd3:  r = 6'd16;
         6'd4:  r = 6'd9;  6'd5:  r = 6'd2;  6'd6:  r = 6'd3;  6'd7:  r = 6'd10;
         6'd8:  r = 6'd17; 6'd9:  r = 6'd24; 6'd10: r = 6'd32; 6'd11: r = 6'd25;
         6'd12: r = 6'd18; 6'd13: r = 6'd11; 6'd14: r = 6'd4;  6'd15: r = 6'd5;
         6'd16: r = 6'd12; 6'd17: r = 6'd19; 6'd18: r = 6'd26; 6'd19: r = 6'd33;
         6'd20: r = 6'd40; 6'd21: r = 6'd48; 6'd22: r = 6'd41; 6'd23: r = 6'd34;
         6'd24: r = 6'd27; 6'd25: r = 6'd20; 6'd26: r = 6'd13; 6'd27: r = 6'd6;
         6'd28: r = 6'd7;  6'd29: r = 6'd14; 6'd30: r = 6'd21; 6'd31: r = 6'd28;
         6'd32: r = 6'd35; 6'd33: r = 6'd42; 6'd34: r = 6'd49; 6'd35: r = 6'd56;
         6'd36: r = 6'd57; 6'd37: r = 6'd50; 6'd38: r = 6'd43; 6'd39: r = 6'd36;
         6'd40: r = 6'd29; 6'd41: r = 6'd22; 6'd42: r = 6'd15; 6'd43: r = 6'd23;
         6'd44: r = 6'd30; 6'd45: r = 6'd37; 6'd46: r = 6'd44; 6'd47: r = 6'd51;
         6'd48: r = 6'd58; 6'd49: r = 6'd59; 6'd50: r = 6'd52; 6'd51: r = 6'd45;
         6'd52: r = 6'd38; 6'd53: r = 6'd31; 6'd54: r = 6'd39; 6'd55: r = 6'd46;
         6'd56: r = 6'd53; 6'd57: r = 6'd60; 6'd58: r = 6'd61; 6'd59: r = 6'd54;
         6'd60: r = 6'd47; 6'd61: r = 6'd55; 6'd62: r = 6'd62; 6'd63: r = 6'd63;
         default: r = 6'd0;
      endcase
      return r;
   endfunction

   // Raster position -> zigzag scan position (inverse of ZZ2RAS).
   function automatic zz_idx_t RAS2ZZ(input zz_idx_t idx);
      zz_idx_t z;
      case (idx)
         6'd0:  z = 6'd0;  6'd1:  z = 6'd1;  6'd2:  z = 6'd5;  6'd3:  z = 6'd6;
         6'd4:  z = 6'd14; 6'd5:  z = 6'd15; 6'd6:  z = 6'd27; 6'd7:  z = 6'd28;
         6'd8:  z = 6'd2;  6'd9:  z = 6'd4;  6'd10: z = 6'd7;  6'd11: z = 6'd13;
         6'd12: z = 6'd16; 6'd13: z = 6'd26; 6'd14: z = 6'd29; 6'd15: z = 6'd42;
         6'd16: z = 6'd3;  6'd17: z = 6'd8;  6'd18: z = 6'd12; 6'd19: z = 6'd17;
         6'd20: z = 6'd25; 6'd21: z = 6'd30; 6'd22: z = 6'd41; 6'd23: z = 6'd43;
         6'd24: z = 6'd9;  6'd25: z = 6'd11; 6'd26: z = 6'd18; 6'd27: z = 6'd24;
         6'd28: z = 6'd31; 6'd29: z = 6'd40; 6'd30: z = 6'd44; 6'd31: z = 6'd53;
         6'd32: z = 6'd10; 6'd33: z = 6'd19; 6'd34: z = 6'd23; 6'd35: z = 6'd32;
         6'd36: z = 6'd39; 6'd37: z = 6'd45; 6'd38: z = 6'd52; 6'd39: z = 6'd54;
         6'd40: z = 6'd20; 6'd41: z = 6'd22; 6'd42: z = 6'd33; 6'd43: z = 6'd38;
         6'd44: z = 6'd46; 6'd45: z = 6'd51; 6'd46: z = 6'd55; 6'd47: z = 6'd60;
         6'd48: z = 6'd21; 6'd49: z = 6'd34; 6'd50: z = 6'd37; 6'd51: z = 6'd47;
         6'd52: z = 6'd50; 6'd53: z = 6'd56; 6'd54: z = 6'd59; 6'd55: z = 6'd61;
         6'd56: z = 6'd35; 6'd57: z = 6'd36; 6'd58: z = 6'd48; 6'd59: z = 6'd49;
         6'd60: z = 6'd57; 6'd61: z = 6'd58; 6'd62: z = 6'd62; 6'd63: z = 6'd63;
         default: z = 6'd0;
      endcase
      return z;
   endfunction

endpackage

// File: rtl/zigzag_bank.sv
// One 64-entry coefficient bank: sync write, async read. With ZZ_LAST_NZ_EN
// defined it also tracks the highest zigzag index holding a nonzero value.
module zigzag_bank
   import zigzag_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic              clk,
`ifdef ZZ_LAST_NZ_EN
   input  logic              rst_n,
`endif
   input  logic              we,
   input  zz_idx_t           waddr,
   input  logic [COEF_W-1:0] wdata,
   input  zz_idx_t           raddr,
   output logic [COEF_W-1:0] rdata
`ifdef ZZ_LAST_NZ_EN
   ,
   output zz_idx_t           last_nz,
   output logic              nz_seen
`endif
);

   logic [COEF_W-1:0] mem [BLK_N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

`ifdef ZZ_LAST_NZ_EN
   zz_idx_t wr_zz;
   logic    wr_nz;

   assign wr_zz = RAS2ZZ(waddr);
   assign wr_nz = (wdata != '0);

   // Raster 0 maps to zigzag 0, so a new block restarts the tracker there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_nz <= '0;
         nz_seen <= 1'b0;
      end else if (we) begin
         if (waddr == '0) begin
            last_nz <= '0;
            nz_seen <= wr_nz;
         end else if (wr_nz && (!nz_seen || (wr_zz > last_nz))) begin
            last_nz <= wr_zz;
            nz_seen <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/zigzag_reorder_buf.sv
// Ping-pong raster-to-zigzag reorder buffer for 8x8 DCT coefficient blocks.
// Optional feature macro: ZZ_LAST_NZ_EN (adds dout_last_nz output).
module zigzag_reorder_buf
   import zigzag_pkg::*;
#(
   parameter int COEF_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [COEF_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [COEF_W-1:0] dout,
   output logic [5:0]        dout_idx,
   output logic              dout_sob,
   output logic              dout_eob,
   output logic              dout_valid,
   input  logic              dout_ready
`ifdef ZZ_LAST_NZ_EN
   ,
   output logic              dout_last_nz
`endif
);

   // Handshake: a beat moves on a rising edge with ena & valid & ready high;
   // ready never looks at valid, and ena=0 freezes both sides completely.

   zz_idx_t           wr_cnt;
   zz_idx_t           rd_cnt;
   zz_idx_t           rd_addr;
   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        bank_full;
   logic [1:0]        full_set;
   logic [1:0]        full_clr;
   logic [1:0]        bank_we;
   logic              in_xfer;
   logic              out_xfer;
   logic              load;
   logic [COEF_W-1:0] bank_rdata [2];
`ifdef ZZ_LAST_NZ_EN
   zz_idx_t           bank_last_nz [2];
   logic [1:0]        bank_nz_seen;
`endif

   assign din_ready = ena & ~bank_full[wr_bank];
   assign in_xfer   = din_valid & din_ready;
   assign out_xfer  = ena & dout_valid & dout_ready;
   assign load      = ena & (~dout_valid | dout_ready) & bank_full[rd_bank];
   assign rd_addr   = ZZ2RAS(rd_cnt);
   assign bank_we   = in_xfer ? (2'b01 << wr_bank) : 2'b00;
   assign full_set  = (in_xfer && (wr_cnt == 6'd63)) ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr  = (load && (rd_cnt == 6'd63)) ? (2'b01 << rd_bank) : 2'b00;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      zigzag_bank #(
         .COEF_W (COEF_W)
      ) u_bank (
         .clk     (clk),
`ifdef ZZ_LAST_NZ_EN
         .rst_n   (rst_n),
`endif
         .we      (bank_we[b]),
         .waddr   (wr_cnt),
         .wdata   (din),
         .raddr   (rd_addr),
         .rdata   (bank_rdata[b])
`ifdef ZZ_LAST_NZ_EN
         ,
         .last_nz (bank_last_nz[b]),
         .nz_seen (bank_nz_seen[b])
`endif
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
      end else if (in_xfer) begin
         wr_cnt <= wr_cnt + 6'd1;
         if (wr_cnt == 6'd63) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   // Set and clear never target the same bank, so both apply in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_full <= 2'b00;
      end else begin
         bank_full <= (bank_full | full_set) & ~full_clr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt     <= '0;
         rd_bank    <= 1'b0;
         dout       <= '0;
         dout_idx   <= '0;
         dout_sob   <= 1'b0;
         dout_eob   <= 1'b0;
         dout_valid <= 1'b0;
      end else if (load) begin
         dout       <= bank_rdata[rd_bank];
         dout_idx   <= rd_cnt;
         dout_sob   <= (rd_cnt == 6'd0);
         dout_eob   <= (rd_cnt == 6'd63);
         dout_valid <= 1'b1;
         rd_cnt     <= rd_cnt + 6'd1;
         if (rd_cnt == 6'd63) begin
            rd_bank <= ~rd_bank;
         end
      end else if (out_xfer) begin
         dout_valid <= 1'b0;
      end
   end

`ifdef ZZ_LAST_NZ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_last_nz <= 1'b0;
      end else if (load) begin
         dout_last_nz <= bank_nz_seen[rd_bank] && (bank_last_nz[rd_bank] == rd_cnt);
      end
   end
`endif

endmodule
